alu_result_buffer: RTL and testbench
====================================

ALU_RESULT_BUFFER -- requirements
Module: alu_result_buffer

Interface
REQ-001 The block SHALL have parameter DEPTH, default 2, giving the number of result entries; legal values are powers of two from 2 to 16.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, the reset; it is synchronous and active-high.
REQ-004 The block SHALL have port in_valid, input, 1, signalling that in_op1/in_op2/in_ans hold a result offered by the subtract stage.
REQ-005 The block SHALL have port in_ready, output, 1, signalling that a free entry is available.
REQ-006 The block SHALL have ports in_op1 and in_op2, input, 8 each, carrying the operands that were fed to the subtractor.
REQ-007 The block SHALL have port in_ans, input, 8, carrying the subtractor result op1-op2 mod 256.
REQ-008 The block SHALL have ports out_valid (output, 1) and out_ready (input, 1), forming the consumer handshake.
REQ-009 The block SHALL have port out_ans, output, 8, carrying the head-entry result.
REQ-010 The block SHALL have ports out_zero, out_neg, out_borrow and out_ovf, output, 1 each, carrying the head-entry flags.
REQ-011 The block SHALL have port count, output, clog2(DEPTH)+1, giving the current occupancy.

Function
REQ-012 A transfer SHALL occur on an edge where in_valid and in_ready are both 1.
REQ-013 On a transfer the block SHALL capture, in one cycle, in_ans and four flags:
- zero = (in_ans==0)
- neg = in_ans[7]
- borrow = (in_op1 < in_op2), unsigned
- ovf = (in_op1[7]!=in_op2[7]) and (in_ans[7]!=in_op1[7])
REQ-014 The buffer SHALL be strictly FIFO, with circular read/write pointers that wrap from DEPTH-1 to 0.
REQ-015 A pop SHALL occur when out_valid and out_ready are both 1; the head then advances on that edge.
REQ-016 Timing SHALL be as follows:
- out_valid = (count!=0) and in_ready = (count!=DEPTH), both registered-state decodes with no combinational input-to-output path.
- Latency from accepted input to out_valid is 1 cycle.
REQ-017 When empty, the block SHALL accept no pop and out_ans/flags SHALL hold their last values.
REQ-018 When full, in_ready SHALL be 0 and in_valid SHALL be ignored, even if a pop occurs on the same edge.
REQ-019 Simultaneous push and pop when 0<count<DEPTH SHALL leave count unchanged and both pointers advanced.
REQ-020 Output data SHALL remain stable while out_valid=1 and out_ready=0.

Reset
REQ-021 When rst=1 on an edge, the block SHALL set pointers, count, out_ans and all flags to 0; out_valid is then 0 and in_ready is 1.
REQ-022 Reset SHALL take priority over push and pop on the same edge, and entries held at reset SHALL be discarded.
REQ-023 Storage array contents SHALL be exempt from reset.

Configuration
REQ-024 With macro ALU_RESULT_STICKY_OVF_EN defined, the block SHALL add:
- output port sticky_ovf (1 bit), set on any transfer with ovf=1 and held until rst.
- input port sticky_clr (1 bit), which clears it on the next edge; a set on that same edge wins.
REQ-025 Without the macro, the block SHALL have neither port and no sticky logic.

Verification
REQ-026 The bench SHALL cover: op1=8'h05, op2=8'h05, ans=8'h00 pushed into empty buffer -> next cycle out_valid=1, out_ans=00, zero=1, neg=0, borrow=0, ovf=0.
REQ-027 The bench SHALL cover: op1=8'h03, op2=8'h07, ans=8'hFC -> neg=1, borrow=1, ovf=0; and op1=8'h80, op2=8'h01, ans=8'h7F -> ovf=1, borrow=0.
REQ-028 The bench SHALL cover: DEPTH=2, out_ready=0, three pushes 11,22,33 -> count=2, in_ready=0, 33 dropped; then out_ready=1 -> outputs 11 then 22, then out_valid=0.
REQ-029 The bench SHALL cover: count=1, push and pop on the same edge for 200 cycles -> count stays 1, values emerge in order, and pointers wrap without loss.
REQ-030 The bench SHALL cover: rst asserted with count=2 while in_valid=1 and out_ready=1 -> next cycle count=0, out_valid=0, in_ready=1, out_ans=00.
REQ-031 The bench SHALL cover, with ALU_RESULT_STICKY_OVF_EN: an ovf push -> sticky_ovf=1 persists after the pop; sticky_clr -> 0; sticky_clr together with an ovf push -> stays 1.

Source files
------------

// File: rtl/alu_result_buffer.sv
// FIFO of subtractor results with derived flags (zero/neg/borrow/ovf); head entry held in a register.
// Optional sticky overflow indicator enabled by defining ALU_RESULT_STICKY_OVF_EN.
module alu_result_buffer #(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [7:0]               in_op1,
  input  logic [7:0]               in_op2,
  input  logic [7:0]               in_ans,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [7:0]               out_ans,
  output logic                     out_zero,
  output logic                     out_neg,
  output logic                     out_borrow,
  output logic                     out_ovf,
`ifdef ALU_RESULT_STICKY_OVF_EN
  input  logic                     sticky_clr,
  output logic                     sticky_ovf,
`endif
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef struct packed {
    logic       ovf;
    logic       borrow;
    logic       neg;
    logic       zero;
    logic [7:0] ans;
  } entry_t;

  entry_t          mem_q [DEPTH];
  entry_t          in_entry;
  entry_t          head_q, head_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]   rd_ptr_next;
  logic [AW:0]     count_q, count_d;
  logic            empty, full, push, pop;

  // Flags are derived once at capture time so the head register can drive outputs directly.
  always_comb begin
    in_entry.ans    = in_ans;
    in_entry.zero   = (in_ans == 8'h00);
    in_entry.neg    = in_ans[7];
    in_entry.borrow = (in_op1 < in_op2);
    in_entry.ovf    = (in_op1[7] != in_op2[7]) && (in_ans[7] != in_op1[7]);
  end

  assign empty     = (count_q == '0);
  assign full      = (count_q == FULL_CNT);
  assign in_ready  = !full;
  assign out_valid = !empty;
  assign push      = in_valid && !full;
  assign pop       = out_ready && !empty;

  // DEPTH is a power of two, so pointer overflow is exactly the DEPTH-1 -> 0 wrap.
  assign rd_ptr_next = rd_ptr_q + 1'b1;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    head_d   = head_q;

    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_next;

    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    // Head register: next entry from storage, or bypass the incoming entry when it becomes the head.
    if (pop) begin
      if (|count_q[AW:1]) begin
        head_d = mem_q[rd_ptr_next];
      end else if (push) begin
        head_d = in_entry;
      end
    end else if (push && empty) begin
      head_d = in_entry;
    end
  end

  // NOTE: storage is deliberately not reset; pointers and count alone define which entries are live.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_entry;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
    end
  end

  assign out_ans    = head_q.ans;
  assign out_zero   = head_q.zero;
  assign out_neg    = head_q.neg;
  assign out_borrow = head_q.borrow;
  assign out_ovf    = head_q.ovf;
  assign count      = count_q;

`ifdef ALU_RESULT_STICKY_OVF_EN
  logic sticky_q, sticky_d;

  // An overflowing transfer on the same edge as a clear wins.
  always_comb begin
    sticky_d = sticky_q;
    if (sticky_clr)             sticky_d = 1'b0;
    if (push && in_entry.ovf)   sticky_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) sticky_q <= 1'b0;
    else     sticky_q <= sticky_d;
  end

  assign sticky_ovf = sticky_q;
`endif

endmodule

// File: tb/tb_alu_result_buffer.sv
// Self-checking bench for alu_result_buffer: directed scenarios plus randomized traffic against a queue model.
module tb_alu_result_buffer;

  localparam int DEPTH = 2;

  logic                   clk;
  logic                   rst;
  logic                   in_valid;
  logic                   in_ready;
  logic [7:0]             in_op1;
  logic [7:0]             in_op2;
  logic [7:0]             in_ans;
  logic                   out_valid;
  logic                   out_ready;
  logic [7:0]             out_ans;
  logic                   out_zero;
  logic                   out_neg;
  logic                   out_borrow;
  logic                   out_ovf;
  logic [$clog2(DEPTH):0] count;
`ifdef ALU_RESULT_STICKY_OVF_EN
  logic                   sticky_clr;
  logic                   sticky_ovf;
`endif

  alu_result_buffer #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op1     (in_op1),
    .in_op2     (in_op2),
    .in_ans     (in_ans),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_ans    (out_ans),
    .out_zero   (out_zero),
    .out_neg    (out_neg),
    .out_borrow (out_borrow),
    .out_ovf    (out_ovf),
`ifdef ALU_RESULT_STICKY_OVF_EN
    .sticky_clr (sticky_clr),
    .sticky_ovf (sticky_ovf),
`endif
    .count      (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] ans;
    logic       z;
    logic       n;
    logic       b;
    logic       o;
  } ent_t;

  ent_t q[$];
  ent_t held;
  bit   m_sticky;
  int   n_total;
  int   n_pass;
  int   n_fail;

  // Flags from arithmetic meaning: signed overflow is a true difference outside -128..127.
  function automatic ent_t model_entry(logic [7:0] a, logic [7:0] b, logic [7:0] r);
    ent_t e;
    int   sd;
    sd    = int'($signed(a)) - int'($signed(b));
    e.ans = r;
    e.z   = (r == 8'd0);
    e.n   = (int'(r) >= 128);
    e.b   = (int'(a) < int'(b));
    e.o   = (sd < -128) || (sd > 127);
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit r, input bit iv, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] ans, input bit ordy);
    rst       = r;
    in_valid  = iv;
    in_op1    = a;
    in_op2    = b;
    in_ans    = ans;
    out_ready = ordy;
  endtask

  // Advance the model with the values present before the edge, then let the edge happen.
  task automatic tick();
    bit   push, pop;
    ent_t e;
    push = in_valid && (q.size() < DEPTH);
    pop  = out_ready && (q.size() > 0);
    if (rst) begin
      q.delete();
      held     = '0;
      m_sticky = 1'b0;
    end else begin
      e = model_entry(in_op1, in_op2, in_ans);
      if (pop)  void'(q.pop_front());
      if (push) q.push_back(e);
`ifdef ALU_RESULT_STICKY_OVF_EN
      if (push && e.o)     m_sticky = 1'b1;
      else if (sticky_clr) m_sticky = 1'b0;
`endif
      if (q.size() > 0) held = q[0];
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".out_valid"},  out_valid,  q.size() != 0);
    chk({tag, ".in_ready"},   in_ready,   q.size() != DEPTH);
    chk({tag, ".count"},      count,      q.size());
    chk({tag, ".out_ans"},    out_ans,    held.ans);
    chk({tag, ".out_zero"},   out_zero,   held.z);
    chk({tag, ".out_neg"},    out_neg,    held.n);
    chk({tag, ".out_borrow"}, out_borrow, held.b);
    chk({tag, ".out_ovf"},    out_ovf,    held.o);
`ifdef ALU_RESULT_STICKY_OVF_EN
    chk({tag, ".sticky_ovf"}, sticky_ovf, m_sticky);
`endif
  endtask

  initial begin
    logic [7:0] a, b;
    n_total = 0;
    n_pass  = 0;
    n_fail  = 0;
    held    = '0;
`ifdef ALU_RESULT_STICKY_OVF_EN
    sticky_clr = 1'b0;
`endif
    drive(1, 0, 8'h00, 8'h00, 8'h00, 0);
    @(negedge clk);

    // Reset state
    tick();
    drive(0, 0, 8'h00, 8'h00, 8'h00, 0);
    check_all("reset");
    chk("reset.const_in_ready", in_ready, 1);
    chk("reset.const_out_valid", out_valid, 0);

    // Zero result into empty buffer: visible one cycle later
    drive(0, 1, 8'h05, 8'h05, 8'h00, 0);
    tick();
    check_all("zero_push");
    chk("zero_push.const_valid", out_valid, 1);
    chk("zero_push.const_zero", out_zero, 1);
    chk("zero_push.const_flags", {out_neg, out_borrow, out_ovf}, 3'b000);
    drive(0, 0, 8'h00, 8'h00, 8'h00, 1);
    tick();
    check_all("zero_pop");

    // Negative with borrow
    drive(0, 1, 8'h03, 8'h07, 8'hFC, 0);
    tick();
    check_all("neg_push");
    chk("neg_push.const_flags", {out_zero, out_neg, out_borrow, out_ovf}, 4'b0110);
    chk("neg_push.const_ans", out_ans, 8'hFC);
    drive(0, 0, 8'h00, 8'h00, 8'h00, 1);
    tick();
    check_all("neg_pop");
    chk("neg_pop.const_hold", out_ans, 8'hFC);

    // Signed overflow without borrow
    drive(0, 1, 8'h80, 8'h01, 8'h7F, 0);
    tick();
    check_all("ovf_push");
    chk("ovf_push.const_flags", {out_zero, out_neg, out_borrow, out_ovf}, 4'b0001);
    drive(0, 0, 8'h00, 8'h00, 8'h00, 1);
    tick();
    check_all("ovf_pop");

    // Fill DEPTH=2 with consumer stalled; third push dropped
    drive(0, 1, 8'h11, 8'h00, 8'h11, 0);
    tick();
    check_all("fill1");
    drive(0, 1, 8'h22, 8'h00, 8'h22, 0);
    tick();
    check_all("fill2");
    drive(0, 1, 8'h33, 8'h00, 8'h33, 0);
    tick();
    check_all("fill3");
    chk("fill3.const_count", count, 2);
    chk("fill3.const_in_ready", in_ready, 0);
    chk("fill3.const_stable", out_ans, 8'h11);
    drive(0, 0, 8'h00, 8'h00, 8'h00, 1);
    tick();
    check_all("drain1");
    chk("drain1.const_ans", out_ans, 8'h22);
    tick();
    check_all("drain2");
    chk("drain2.const_valid", out_valid, 0);

    // Full with simultaneous pop: incoming entry is ignored
    drive(0, 1, 8'h40, 8'h01, 8'h3F, 0);
    tick();
    drive(0, 1, 8'h50, 8'h01, 8'h4F, 0);
    tick();
    drive(0, 1, 8'h60, 8'h01, 8'h5F, 1);
    tick();
    check_all("full_pop");
    chk("full_pop.const_count", count, 1);
    chk("full_pop.const_ans", out_ans, 8'h4F);

    // Streaming at count=1 for 200 cycles: pointers wrap repeatedly
    for (int i = 0; i < 200; i++) begin
      a = 8'($urandom);
      b = 8'($urandom);
      drive(0, 1, a, b, a - b, 1);
      tick();
      check_all("stream");
      chk("stream.const_count", count, 1);
    end

    // Reset with two entries while both handshakes are active
    drive(0, 0, 8'h00, 8'h00, 8'h00, 1);
    tick();
    drive(0, 1, 8'hA0, 8'h10, 8'h90, 0);
    tick();
    drive(0, 1, 8'hB0, 8'h10, 8'hA0, 0);
    tick();
    chk("pre_rst.const_count", count, 2);
    drive(1, 1, 8'hC0, 8'h10, 8'hB0, 1);
    tick();
    drive(0, 0, 8'h00, 8'h00, 8'h00, 0);
    check_all("rst_full");
    chk("rst_full.const_count", count, 0);
    chk("rst_full.const_ans", out_ans, 8'h00);
    chk("rst_full.const_in_ready", in_ready, 1);

`ifdef ALU_RESULT_STICKY_OVF_EN
    // Sticky overflow: persists after pop, clears, and set beats clear
    drive(0, 1, 8'h80, 8'h01, 8'h7F, 0);
    tick();
    drive(0, 0, 8'h00, 8'h00, 8'h00, 1);
    tick();
    check_all("sticky_after_pop");
    chk("sticky_after_pop.const", sticky_ovf, 1);
    sticky_clr = 1'b1;
    tick();
    sticky_clr = 1'b0;
    check_all("sticky_clr");
    chk("sticky_clr.const", sticky_ovf, 0);
    sticky_clr = 1'b1;
    drive(0, 1, 8'h7F, 8'hFF, 8'h80, 1);
    tick();
    sticky_clr = 1'b0;
    check_all("sticky_set_wins");
    chk("sticky_set_wins.const", sticky_ovf, 1);
`endif

    // Randomized traffic with occasional reset
    for (int i = 0; i < 400; i++) begin
      a = 8'($urandom);
      b = 8'($urandom);
`ifdef ALU_RESULT_STICKY_OVF_EN
      sticky_clr = ($urandom_range(0, 7) == 0);
`endif
      drive(($urandom_range(0, 63) == 0), $urandom_range(0, 1), a, b, a - b,
            $urandom_range(0, 1));
      tick();
      check_all("random");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
